// File: rtl/quad_decoder_pkg.sv
// Shared encodings and the transition classifier for the quadrature decoder.
package quad_decoder_pkg;

  // State is {filt_a, filt_b}.
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_UP      = 2'd1,
    DIR_DOWN    = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_e;

  // Forward rotation is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    logic [1:0] r;
    case (s)
      S00:     r = S10;
      S10:     r = S11;
      S11:     r = S01;
      default: r = S00;
    endcase
    return r;
  endfunction

  function automatic dir_e quad_dir(input logic [1:0] prev_s, input logic [1:0] next_s);
    dir_e r;
    if (prev_s == next_s) begin
      r = DIR_NONE;
    end else if ((prev_s ^ next_s) == 2'b11) begin
      r = DIR_ILLEGAL;
    end else if (next_s == fwd_next(prev_s)) begin
      r = DIR_UP;
    end else begin
      r = DIR_DOWN;
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_input_filter.sv
// One quadrature channel: synchronizer chain followed by a stability filter.
module quad_input_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic filt_nxt_o_c,
  output logic stable_o_c
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       diff_q, diff_d;
  logic [CNT_W-1:0]       same_q, same_d;
  logic                   synced;
  logic                   synced_vld;

  // vld_q tracks which sync stages hold a post-reset sample.
  assign synced     = sync_q[SYNC_STAGES-1];
  assign synced_vld = vld_q[SYNC_STAGES-1];

  always_comb begin
    filt_d = filt_q;
    diff_d = diff_q;
    same_d = same_q;
    if (synced_vld) begin
      if (synced == filt_q) begin
        diff_d = '0;
        if (same_q != CNT_W'(FILTER_LEN)) same_d = same_q + CNT_W'(1);
      end else begin
        same_d = '0;
        if (diff_q == CNT_W'(FILTER_LEN - 1)) begin
          filt_d = synced;
          diff_d = '0;
          same_d = CNT_W'(FILTER_LEN);
        end else begin
          diff_d = diff_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      vld_q  <= '0;
      filt_q <= 1'b0;
      diff_q <= '0;
      same_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      filt_q <= filt_d;
      diff_q <= diff_d;
      same_q <= same_d;
    end
  end

  // Next filtered level lets the top register step on the same edge filt moves.
  assign filt_nxt_o_c = filt_d;
  assign stable_o_c   = (same_q == CNT_W'(FILTER_LEN));

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B channels to step/up strobes, position and sticky error.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int unsigned BITS        = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_in,
  input  logic            b_in,
  input  logic            enable,
  input  logic            clear,
  input  logic            err_clr,
  output logic            step,
  output logic            up,
  output logic [BITS-1:0] pos,
  output logic            err
);

  logic            a_nxt, b_nxt, a_stable, b_stable;
  logic            primed_q, primed_d;
  logic [1:0]      s_q, s_d, s_nxt;
  logic            step_q, step_d;
  logic            up_q, up_d;
  logic [BITS-1:0] pos_q, pos_d;
  logic            err_q, err_d;
  dir_e            dir;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk          (clk),
    .reset        (reset),
    .din_i        (a_in),
    .filt_nxt_o_c (a_nxt),
    .stable_o_c   (a_stable)
  );

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk          (clk),
    .reset        (reset),
    .din_i        (b_in),
    .filt_nxt_o_c (b_nxt),
    .stable_o_c   (b_stable)
  );

  assign s_nxt = {a_nxt, b_nxt};
  assign dir   = quad_dir(s_q, s_nxt);

  // State tracks the filters even while disabled so re-enabling is glitch-free.
  always_comb begin
    primed_d = primed_q;
    s_d      = s_q;
    step_d   = 1'b0;
    up_d     = up_q;
    pos_d    = pos_q;
    err_d    = err_q & ~err_clr;
    if (!primed_q) begin
      if (a_stable && b_stable) begin
        primed_d = 1'b1;
        s_d      = s_nxt;
      end
    end else begin
      s_d = s_nxt;
      case (dir)
        DIR_UP: begin
          if (enable) begin
            step_d = 1'b1;
            up_d   = 1'b1;
            pos_d  = pos_q + BITS'(1);
          end
        end
        DIR_DOWN: begin
          if (enable) begin
            step_d = 1'b1;
            up_d   = 1'b0;
            pos_d  = pos_q - BITS'(1);
          end
        end
        DIR_ILLEGAL: err_d = 1'b1;
        default: ;
      endcase
    end
    if (clear) pos_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      primed_q <= 1'b0;
      s_q      <= S00;
      step_q   <= 1'b0;
      up_q     <= 1'b0;
      pos_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      primed_q <= primed_d;
      s_q      <= s_d;
      step_q   <= step_d;
      up_q     <= up_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
    end
  end

  assign step = step_q;
  assign up   = up_q;
  assign pos  = pos_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed vector table, hand sequences, random walk vs sample-window model.
module tb_quad_decoder;

  localparam int unsigned BITS = 16;
  localparam int unsigned SYNC = 2;
  localparam int unsigned FL   = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            a_in = 1'b0, b_in = 1'b0;
  logic            enable = 1'b1, clear = 1'b0, err_clr = 1'b0;
  logic            step, up, err;
  logic [BITS-1:0] pos;

  quad_decoder #(.BITS(BITS), .SYNC_STAGES(SYNC), .FILTER_LEN(FL)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_in    (a_in),
    .b_in    (b_in),
    .enable  (enable),
    .clear   (clear),
    .err_clr (err_clr),
    .step    (step),
    .up      (up),
    .pos     (pos),
    .err     (err)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;
  int nsteps = 0;

  // Reference model state: raw samples since reset and the expected outputs.
  bit              qa[$];
  bit              qb[$];
  bit              m_fa, m_fb, m_sta, m_stb, m_primed;
  bit              m_step, m_up, m_err;
  logic [BITS-1:0] m_pos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Filter decision from the window of FL samples taken SYNC edges ago.
  function automatic void win(input bit q[$], input bit filt, output bit nf, output bit st);
    int  base;
    bit  same;
    bit  v;
    nf = filt;
    st = 1'b0;
    if (q.size() >= int'(SYNC + FL)) begin
      base = q.size() - 1 - int'(SYNC);
      v    = q[base];
      same = 1'b1;
      for (int j = 0; j < int'(FL); j++) if (q[base - j] != v) same = 1'b0;
      if (same && v != filt) nf = v;
      st = same && (v == nf);
    end
  endfunction

  // Position of a state along the forward rotation (Gray to binary).
  function automatic int gidx(input bit a, input bit b);
    return int'({b, a ^ b});
  endfunction

  function automatic void model_step(input bit a, input bit b, input bit en,
                                     input bit clr, input bit eclr, input bit rst);
    bit nfa, nfb, sta, stb;
    int d;
    if (rst) begin
      qa.delete(); qb.delete();
      m_fa = 0; m_fb = 0; m_sta = 0; m_stb = 0; m_primed = 0;
      m_step = 0; m_up = 0; m_pos = '0; m_err = 0;
      return;
    end
    qa.push_back(a);
    qb.push_back(b);
    if (qa.size() > 64) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    win(qa, m_fa, nfa, sta);
    win(qb, m_fb, nfb, stb);
    m_step = 0;
    m_err  = m_err && !eclr;
    if (!m_primed) begin
      if (m_sta && m_stb) m_primed = 1;
    end else begin
      d = (gidx(nfa, nfb) - gidx(m_fa, m_fb) + 4) % 4;
      if (d == 2) m_err = 1;
      else if (en && d == 1) begin m_step = 1; m_up = 1; m_pos = m_pos + 16'd1; end
      else if (en && d == 3) begin m_step = 1; m_up = 0; m_pos = m_pos - 16'd1; end
    end
    if (clr) m_pos = '0;
    m_fa = nfa; m_fb = nfb; m_sta = sta; m_stb = stb;
  endfunction

  // One clock: drive inputs, let the edge pass, compare against the model.
  task automatic tick(input bit a, input bit b, input bit en,
                      input bit clr, input bit eclr, input bit rst);
    a_in = a; b_in = b; enable = en; clear = clr; err_clr = eclr; reset = rst;
    @(posedge clk);
    #1;
    model_step(a, b, en, clr, eclr, rst);
    if (step === 1'b1) nsteps++;
    chk("model_step", 32'(step), 32'(m_step));
    chk("model_up",   32'(up),   32'(m_up));
    chk("model_pos",  32'(pos),  32'(m_pos));
    chk("model_err",  32'(err),  32'(m_err));
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    for (int i = 0; i < n; i++) tick(a, b, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit              a, b, en, clr, eclr;
    int              cycles;
    int              exp_steps;
    logic [BITS-1:0] exp_pos;
    bit              exp_up, exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int s0;
    int len;
    bit ra, rb, ren;
    int r;

    vecs[0]  = '{1,0,1,0,0, 10, 1, 16'd1,    1, 0};
    vecs[1]  = '{1,1,1,0,0, 10, 1, 16'd2,    1, 0};
    vecs[2]  = '{0,1,1,0,0, 10, 1, 16'd3,    1, 0};
    vecs[3]  = '{0,0,1,0,0, 10, 1, 16'd4,    1, 0};
    vecs[4]  = '{0,0,1,1,0, 10, 0, 16'd0,    1, 0};
    vecs[5]  = '{0,1,1,0,0, 10, 1, 16'hFFFF, 0, 0};
    vecs[6]  = '{0,0,1,0,0, 10, 1, 16'd0,    1, 0};
    vecs[7]  = '{1,1,1,0,0, 10, 0, 16'd0,    1, 1};
    vecs[8]  = '{1,1,1,0,1, 10, 0, 16'd0,    1, 0};
    vecs[9]  = '{0,0,1,0,0, 10, 0, 16'd0,    1, 1};
    vecs[10] = '{0,0,1,0,1, 10, 0, 16'd0,    1, 0};
    vecs[11] = '{1,0,0,0,0, 10, 0, 16'd0,    1, 0};
    vecs[12] = '{1,1,0,0,0, 10, 0, 16'd0,    1, 0};
    vecs[13] = '{0,1,0,0,0, 10, 0, 16'd0,    1, 0};
    vecs[14] = '{0,1,1,0,0, 10, 0, 16'd0,    1, 0};
    vecs[15] = '{0,0,1,0,0, 10, 1, 16'd1,    1, 0};

    // Reset state
    tick(0, 0, 1, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 1);
    chk("reset_step", 32'(step), 32'd0);
    chk("reset_up",   32'(up),   32'd0);
    chk("reset_pos",  32'(pos),  32'd0);
    chk("reset_err",  32'(err),  32'd0);
    hold(0, 0, 10);

    foreach (vecs[i]) begin
      s0 = nsteps;
      for (int c = 0; c < vecs[i].cycles; c++)
        tick(vecs[i].a, vecs[i].b, vecs[i].en,
             (c == 0) ? vecs[i].clr : 1'b0, (c == 0) ? vecs[i].eclr : 1'b0, 1'b0);
      chk($sformatf("vec%0d_steps", i), 32'(nsteps - s0), 32'(vecs[i].exp_steps));
      chk($sformatf("vec%0d_pos", i),   32'(pos), 32'(vecs[i].exp_pos));
      chk($sformatf("vec%0d_up", i),    32'(up),  32'(vecs[i].exp_up));
      chk($sformatf("vec%0d_err", i),   32'(err), 32'(vecs[i].exp_err));
    end

    // Latency: step lands exactly SYNC+FL-1 edges after the sampling edge.
    tick(1, 0, 1, 0, 0, 0);
    for (int i = 1; i < int'(SYNC + FL - 1); i++) begin
      tick(1, 0, 1, 0, 0, 0);
      chk("lat_early", 32'(step), 32'd0);
    end
    tick(1, 0, 1, 0, 0, 0);
    chk("lat_step", 32'(step), 32'd1);
    chk("lat_pos",  32'(pos),  32'd2);
    tick(1, 0, 1, 0, 0, 0);
    chk("lat_width", 32'(step), 32'd0);
    hold(1, 0, 5);

    // Glitch on b shorter than the filter window is rejected.
    s0 = nsteps;
    hold(1, 1, 2);
    hold(1, 0, 10);
    chk("glitch_steps", 32'(nsteps - s0), 32'd0);
    chk("glitch_pos",   32'(pos), 32'd2);
    chk("glitch_err",   32'(err), 32'd0);
    hold(1, 1, 10);
    chk("post_glitch_steps", 32'(nsteps - s0), 32'd1);
    chk("post_glitch_pos",   32'(pos), 32'd3);
    chk("post_glitch_up",    32'(up),  32'd1);

    // Illegal transition landing on the same edge as err_clr keeps err set.
    tick(0, 0, 1, 0, 0, 0);
    hold(0, 0, int'(SYNC + FL - 2));
    chk("ill_pre_err", 32'(err), 32'd0);
    tick(0, 0, 1, 0, 1, 0);
    chk("ill_clr_err", 32'(err), 32'd1);
    chk("ill_clr_pos", 32'(pos), 32'd3);
    tick(0, 0, 1, 0, 1, 0);
    chk("ill_cleared", 32'(err), 32'd0);
    hold(0, 0, 5);

    // Clear coincident with a step at pos=7.
    hold(1, 0, 8); hold(1, 1, 8); hold(0, 1, 8); hold(0, 0, 8);
    chk("pre_clear_pos", 32'(pos), 32'd7);
    tick(1, 0, 1, 0, 0, 0);
    hold(1, 0, int'(SYNC + FL - 2));
    tick(1, 0, 1, 1, 0, 0);
    chk("clr_step", 32'(step), 32'd1);
    chk("clr_up",   32'(up),   32'd1);
    chk("clr_pos",  32'(pos),  32'd0);
    hold(1, 0, 5);

    // Mid-count reset with a=b=1; priming on 11 must not flag 00->11.
    hold(1, 1, 8); hold(0, 1, 8); hold(0, 0, 8); hold(1, 0, 8); hold(1, 1, 8);
    chk("pre_rst_pos", 32'(pos), 32'd5);
    tick(1, 1, 1, 0, 0, 1);
    chk("rst_pos",  32'(pos),  32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_step", 32'(step), 32'd0);
    s0 = nsteps;
    hold(1, 1, 15);
    chk("prime_steps", 32'(nsteps - s0), 32'd0);
    chk("prime_err",   32'(err), 32'd0);
    hold(0, 1, 10);
    chk("prime_next_steps", 32'(nsteps - s0), 32'd1);
    chk("prime_next_up",    32'(up),  32'd1);
    chk("prime_next_pos",   32'(pos), 32'd1);

    // Random walk with short holds, illegal jumps, enable/clear/err_clr/reset noise.
    ra = 0; rb = 1;
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin ra = !ra; rb = !rb; end
      else if (r <= 4) ra = !ra;
      else if (r <= 7) rb = !rb;
      len = $urandom_range(1, 12);
      ren = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < len; c++)
        tick(ra, rb, ren, $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 499) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
